axi_reg_arbiter: RTL

//   Shares the AXI register slave (8-entry BRAM + CRC word) between NUM_REQ local requesters.

---
 rtl/axi_reg_arbiter.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_reg_arbiter.sv
// Round-robin arbiter that lets NUM_REQ local requesters share one AXI register slave, one transaction at a time.
// Latency with a zero-wait slave: accept at T, AW/W or AR at T+1, B or R at T+2, rsp_valid_o at T+3 (4 cycles min per txn).
// Backpressure: requests wait until req_ready_o pulses; AXI valids hold their payload until the slave handshakes.
//
// Ports:
//   clk, areset (async, active low)
//   req_valid_i/req_write_i/req_addr_i/req_wdata_i/req_wstrb_i : per-requester command, slice i = requester i
//   req_ready_o : one-hot accept pulse;  rsp_valid_o : one-hot completion pulse with rsp_data_o/rsp_err_o
//   aw*/w*/b*/ar*/r* : AXI master channels, transaction id = granted requester index
// Optional build macro ARB_STATS_EN: adds grant_cnt_o, one 16-bit saturating grant counter per requester.
module axi_reg_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_REQ    = 2
) (
    input  logic                               clk,
    input  logic                               areset,
    input  logic [NUM_REQ-1:0]                 req_valid_i,
    input  logic [NUM_REQ-1:0]                 req_write_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]      req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_wdata_i,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]  req_wstrb_i,
    output logic [NUM_REQ-1:0]                 req_ready_o,
    output logic [NUM_REQ-1:0]                 rsp_valid_o,
    output logic [DATA_WIDTH-1:0]              rsp_data_o,
    output logic                               rsp_err_o,
    output logic [3:0]                         awid_o,
    output logic [ADDR_WIDTH-1:0]              awaddr_o,
    output logic                               awvalid_o,
    input  logic                               awready_i,
    output logic [3:0]                         wid_o,
    output logic [DATA_WIDTH-1:0]              wdata_o,
    output logic [DATA_WIDTH/8-1:0]            wstrb_o,
    output logic                               wlast_o,
    output logic                               wvalid_o,
    input  logic                               wready_i,
    input  logic [3:0]                         bid_i,
    input  logic [1:0]                         bresp_i,
    input  logic                               bvalid_i,
    output logic                               bready_o,
    output logic [3:0]                         arid_o,
    output logic [ADDR_WIDTH-1:0]              araddr_o,
    output logic                               arvalid_o,
    input  logic                               arready_i,
    input  logic [3:0]                         rid_i,
    input  logic [DATA_WIDTH-1:0]              rdata_i,
    input  logic                               rlast_i,
    input  logic                               rvalid_i,
    output logic                               rready_o
`ifdef ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]              grant_cnt_o
`endif
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int GW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR_AD = 3'd1,
        S_WR_B  = 3'd2,
        S_RD_A  = 3'd3,
        S_RD_D  = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [GW-1:0]           last_grant_q, last_grant_d;
    logic [GW-1:0]           gnt_q, gnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic                    rsp_err_q, rsp_err_d;

    logic                    found;
    logic [GW-1:0]           pick;
    logic                    aw_hs;
    logic                    w_hs;
    logic [3:0]              txn_id;

    // Ids, rlast and the response ids are not needed: only one transaction is ever outstanding.
    logic                    unused_inputs;
    assign unused_inputs = ^{bid_i, rid_i, rlast_i};

    assign txn_id = 4'(gnt_q);

    // Rotating priority: search upward from the requester after the last grant, wrapping around.
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(last_grant_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_valid_i[idx]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;

        req_ready_o  = '0;
        rsp_valid_o  = '0;
        rsp_data_o   = '0;
        rsp_err_o    = 1'b0;
        awvalid_o    = 1'b0;
        wvalid_o     = 1'b0;
        bready_o     = 1'b0;
        arvalid_o    = 1'b0;
        rready_o     = 1'b0;
        aw_hs        = 1'b0;
        w_hs         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    req_ready_o[pick] = 1'b1;
                    gnt_d        = pick;
                    last_grant_d = pick;
                    addr_d       = req_addr_i[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d      = req_wdata_i[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
                    wstrb_d      = req_wstrb_i[int'(pick)*STRB_W +: STRB_W];
                    aw_done_d    = 1'b0;
                    w_done_d     = 1'b0;
                    state_d      = req_write_i[pick] ? S_WR_AD : S_RD_A;
                end
            end
            S_WR_AD: begin
                // AW and W complete independently; each valid drops after its own handshake.
                awvalid_o = !aw_done_q;
                wvalid_o  = !w_done_q;
                aw_hs     = awvalid_o && awready_i;
                w_hs      = wvalid_o && wready_i;
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
                if (aw_done_d && w_done_d) begin
                    state_d = S_WR_B;
                end
            end
            S_WR_B: begin
                bready_o = 1'b1;
                if (bvalid_i) begin
                    rsp_err_d  = (bresp_i != 2'b00);
                    rsp_data_d = '0;
                    state_d    = S_RESP;
                end
            end
            S_RD_A: begin
                arvalid_o = 1'b1;
                if (arready_i) begin
                    state_d = S_RD_D;
                end
            end
            S_RD_D: begin
                rready_o = 1'b1;
                if (rvalid_i) begin
                    rsp_data_d = rdata_i;
                    rsp_err_d  = 1'b0;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid_o[gnt_q] = 1'b1;
                rsp_data_o         = rsp_data_q;
                rsp_err_o          = rsp_err_q;
                state_d            = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Payloads are zero whenever their channel is not presenting a transfer.
    assign awaddr_o = awvalid_o ? addr_q : '0;
    assign awid_o   = awvalid_o ? txn_id : 4'd0;
    assign wdata_o  = wvalid_o ? wdata_q : '0;
    assign wstrb_o  = wvalid_o ? wstrb_q : '0;
    assign wid_o    = wvalid_o ? txn_id : 4'd0;
    assign wlast_o  = wvalid_o;
    assign araddr_o = arvalid_o ? addr_q : '0;
    assign arid_o   = arvalid_o ? txn_id : 4'd0;

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q      <= S_IDLE;
            last_grant_q <= GW'(NUM_REQ - 1);
            gnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

`ifdef ARB_STATS_EN
    logic [NUM_REQ*16-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready_o[i] && (cnt_q[i*16 +: 16] != 16'hFFFF)) begin
                cnt_d[i*16 +: 16] = cnt_q[i*16 +: 16] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign grant_cnt_o = cnt_q;
`endif

endmodule
